uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter.
// Frame: start bit (0), DATA_BITS payload bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit is held for CLK_DIV cycles of CLK_TX.
// Optional feature: define UART_TX_BREAK_EN to add the BRK input. While BRK is
// held in IDLE, the line is forced low.
module uart_tx_param #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 CLK_TX,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] DATA,
   input  logic                 WR_EN,
`ifdef UART_TX_BREAK_EN
   input  logic                 BRK,
`endif
   output logic                 TX,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_TX_BREAK_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`endif

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par;
   logic                 bit_end_c;

   // Last cycle of the current bit period.
   assign bit_end_c = (cnt == CNT_W'(CLK_DIV - 1));

   // Transmit FSM with registered line, busy and done outputs.
   always_ff @(posedge CLK_TX) begin
      if (!RST) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
         TX       <= 1'b1;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
`ifdef UART_TX_BREAK_EN
               if (BRK) begin
                  state <= S_BREAK;
                  TX    <= 1'b0;
                  BUSY  <= 1'b1;
               end else
`endif
               if (WR_EN) begin
                  shreg <= DATA;
                  par   <= (^DATA) ^ (PARITY == 1);
                  TX    <= 1'b0;
                  BUSY  <= 1'b1;
                  state <= S_START;
               end
            end

            S_START: begin
               if (bit_end_c) begin
                  cnt   <= '0;
                  idx   <= '0;
                  TX    <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= S_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (bit_end_c) begin
                  cnt <= '0;
                  if (idx == IDX_W'(DATA_BITS - 1)) begin
                     idx <= '0;
                     if (PARITY != 0) begin
                        TX    <= par;
                        state <= S_PARITY;
                     end else begin
                        TX       <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= S_STOP;
                     end
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     TX    <= shreg[0];
                     shreg <= shreg >> 1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_PARITY: begin
               if (bit_end_c) begin
                  cnt      <= '0;
                  TX       <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= S_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_STOP: begin
               if (bit_end_c) begin
                  cnt <= '0;
                  if (stop_idx == 1'(STOP_BITS - 1)) begin
                     stop_idx <= 1'b0;
                     BUSY     <= 1'b0;
                     DONE     <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
               if (!BRK) begin
                  TX    <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= S_IDLE;
               end
            end
`endif

            default: begin
               state <= S_IDLE;
               TX    <= 1'b1;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: self-checking bench for uart_tx_param over five
// parameter sets, with a frame-level reference model.
module tb_uart_tx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] rst, wr, tx, busy, done;
   logic [8:0] data [5];
`ifdef UART_TX_BREAK_EN
   logic [4:0] brk;
`endif

   // Per-instance configuration: 8N1, 8E1, 8N2, 8O1 (all div 4), 5E2 div 3.
   int db_p [5] = '{8, 8, 8, 8, 5};
   int dv_p [5] = '{4, 4, 4, 4, 3};
   int pa_p [5] = '{0, 2, 0, 1, 2};
   int st_p [5] = '{1, 1, 2, 1, 2};

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) u0 (
      .CLK_TX(clk), .RST(rst[0]), .DATA(data[0][7:0]), .WR_EN(wr[0]),
`ifdef UART_TX_BREAK_EN
      .BRK(brk[0]),
`endif
      .TX(tx[0]), .BUSY(busy[0]), .DONE(done[0]));

   uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(2), .STOP_BITS(1)) u1 (
      .CLK_TX(clk), .RST(rst[1]), .DATA(data[1][7:0]), .WR_EN(wr[1]),
`ifdef UART_TX_BREAK_EN
      .BRK(brk[1]),
`endif
      .TX(tx[1]), .BUSY(busy[1]), .DONE(done[1]));

   uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(0), .STOP_BITS(2)) u2 (
      .CLK_TX(clk), .RST(rst[2]), .DATA(data[2][7:0]), .WR_EN(wr[2]),
`ifdef UART_TX_BREAK_EN
      .BRK(brk[2]),
`endif
      .TX(tx[2]), .BUSY(busy[2]), .DONE(done[2]));

   uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1)) u3 (
      .CLK_TX(clk), .RST(rst[3]), .DATA(data[3][7:0]), .WR_EN(wr[3]),
`ifdef UART_TX_BREAK_EN
      .BRK(brk[3]),
`endif
      .TX(tx[3]), .BUSY(busy[3]), .DONE(done[3]));

   uart_tx_param #(.DATA_BITS(5), .CLK_DIV(3), .PARITY(2), .STOP_BITS(2)) u4 (
      .CLK_TX(clk), .RST(rst[4]), .DATA(data[4][4:0]), .WR_EN(wr[4]),
`ifdef UART_TX_BREAK_EN
      .BRK(brk[4]),
`endif
      .TX(tx[4]), .BUSY(busy[4]), .DONE(done[4]));

   typedef struct {
      int          inst;
      logic [8:0]  d;
      logic [15:0] bits;   // line bits in transmit order, bit 0 first
      int          nb;
      logic        pulse;  // inject a WR_EN pulse mid-frame
   } vec_t;

   vec_t tbl [10];

   // Compare {TX,BUSY,DONE} of one instance against the required value.
   task automatic chk(input string nm, input int i, input logic [2:0] exp);
      logic [2:0] act;
      act = {tx[i], busy[i], done[i]};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t: tx,busy,done=%b required %b",
                  nm, i, $time, act, exp);
      end
   endtask

   // Reference frame: start, payload LSB first, parity, stop bits.
   function automatic void model(input int i, input logic [8:0] d,
                                 output logic [15:0] bits, output int nb);
      logic p;
      bits = '0;
      nb   = 1;
      p    = 1'b0;
      for (int b = 0; b < db_p[i]; b++) begin
         bits[nb] = d[b];
         p        = p ^ d[b];
         nb++;
      end
      if (pa_p[i] != 0) begin
         bits[nb] = (pa_p[i] == 1) ? ~p : p;
         nb++;
      end
      for (int s = 0; s < st_p[i]; s++) begin
         bits[nb] = 1'b1;
         nb++;
      end
   endfunction

   // Check every cycle of a frame whose accepting edge is the next posedge.
   task automatic frame_cycles(input int i, input logic [15:0] bits, input int nb,
                               input logic drop, input logic [8:0] nd,
                               input logic pulse, input string nm);
      int dv;
      dv = dv_p[i];
      for (int c = 0; c < nb * dv; c++) begin
         @(posedge clk); #1;
         chk(nm, i, {bits[c / dv], 2'b10});
         if (c == 0) begin
            data[i] = nd;
            if (drop) wr[i] = 1'b0;
         end
         if (pulse && c == 2 * dv) begin
            wr[i]   = 1'b1;
            data[i] = 9'($urandom);
         end
         if (pulse && c == 2 * dv + 1) wr[i] = 1'b0;
      end
   endtask

   // One full write: accept, frame, DONE pulse, back to idle.
   task automatic send_check(input int i, input logic [8:0] d, input logic [15:0] bits,
                             input int nb, input logic pulse, input string nm);
      @(negedge clk);
      data[i] = d;
      wr[i]   = 1'b1;
      frame_cycles(i, bits, nb, 1'b1, ~d, pulse, nm);
      @(posedge clk); #1;
      chk({nm, "_done"}, i, 3'b101);
      @(posedge clk); #1;
      chk({nm, "_idle"}, i, 3'b100);
   endtask

   initial begin
      logic [15:0] b1, b2;
      int          n1, n2, ri;
      logic [8:0]  rd;

      tbl[0] = '{0, 9'h0A5, 16'b1101001010,  10, 1'b1};
      tbl[1] = '{0, 9'h000, 16'b1000000000,  10, 1'b0};
      tbl[2] = '{0, 9'h0FF, 16'b1111111110,  10, 1'b0};
      tbl[3] = '{1, 9'h007, 16'b11000001110, 11, 1'b0};
      tbl[4] = '{1, 9'h000, 16'b10000000000, 11, 1'b1};
      tbl[5] = '{2, 9'h0A5, 16'b11101001010, 11, 1'b0};
      tbl[6] = '{3, 9'h007, 16'b10000001110, 11, 1'b0};
      tbl[7] = '{3, 9'h000, 16'b11000000000, 11, 1'b0};
      tbl[8] = '{4, 9'h015, 16'b111101010,    9, 1'b1};
      tbl[9] = '{4, 9'h00E, 16'b111011100,    9, 1'b0};

      rst = '0;
      wr  = '0;
      for (int i = 0; i < 5; i++) data[i] = '0;
`ifdef UART_TX_BREAK_EN
      brk = '0;
`endif

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) chk("reset", i, 3'b100);
      rst = '1;

      // Hand-derived frames.
      for (int k = 0; k < 10; k++)
         send_check(tbl[k].inst, tbl[k].d, tbl[k].bits, tbl[k].nb, tbl[k].pulse, "table");

      // Back-to-back frames with WR_EN held high throughout.
      @(negedge clk);
      data[0] = 9'h055;
      wr[0]   = 1'b1;
      model(0, 9'h055, b1, n1);
      frame_cycles(0, b1, n1, 1'b0, 9'h033, 1'b0, "b2b_a");
      @(posedge clk); #1;
      chk("b2b_gap", 0, 3'b101);
      model(0, 9'h033, b2, n2);
      frame_cycles(0, b2, n2, 1'b1, 9'h000, 1'b0, "b2b_b");
      @(posedge clk); #1;
      chk("b2b_done", 0, 3'b101);
      @(posedge clk); #1;
      chk("b2b_idle", 0, 3'b100);

      // Reset on the 13th edge of a frame, then a clean frame.
      @(negedge clk);
      data[0] = 9'h0A5;
      wr[0]   = 1'b1;
      model(0, 9'h0A5, b1, n1);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         chk("prerst", 0, {b1[c / 4], 2'b10});
         if (c == 0) wr[0] = 1'b0;
      end
      rst[0] = 1'b0;
      @(posedge clk); #1;
      chk("midrst", 0, 3'b100);
      rst[0] = 1'b1;
      @(posedge clk); #1;
      chk("rst_nodone", 0, 3'b100);
      model(0, 9'h03C, b1, n1);
      send_check(0, 9'h03C, b1, n1, 1'b0, "postrst");

      // Randomized frames against the model.
      for (int r = 0; r < 20; r++) begin
         ri = $urandom_range(0, 4);
         rd = 9'($urandom) & 9'((1 << db_p[ri]) - 1);
         model(ri, rd, b1, n1);
         send_check(ri, rd, b1, n1, 1'($urandom_range(0, 1)), "rand");
      end

`ifdef UART_TX_BREAK_EN
      // Break held 50 cycles in IDLE, write attempt ignored.
      @(negedge clk);
      brk[0] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         chk("break", 0, 3'b010);
         if (c == 5) begin
            wr[0]   = 1'b1;
            data[0] = 9'h0C3;
         end
         if (c == 10) wr[0] = 1'b0;
      end
      brk[0] = 1'b0;
      @(posedge clk); #1;
      chk("brk_release", 0, 3'b100);
      @(posedge clk); #1;
      chk("brk_idle", 0, 3'b100);
      model(0, 9'h069, b1, n1);
      send_check(0, 9'h069, b1, n1, 1'b0, "postbrk");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
